agc_dual_rate: RTL and testbench
================================

Name: agc_dual_rate

Overview:
- Parametrised closed-loop automatic gain control for complex I/Q samples.
- Scales each valid input pair by a common gain and drives the output peak magnitude, max(|I|,|Q|), toward a runtime target.
- Separate attack (fast, gain down) and release (slow, gain up) loop rates; gain clamp, hold, gain preload, saturation and lock indication.
- Sits between the decimating front end and the adaptive filter stage. Uses a valid-qualified sample stream in place of a free-running enable.

Parameters:
SAMPLE_W, 16, sample width, signed two's complement
SAMPLE_FR, 15, sample fractional bits
GAIN_W, 16, gain width, signed; gain value always positive
GAIN_FR, 8, gain fractional bits
ATTACK_SHIFT, 3, loop shift used when err < 0; must be <= RELEASE_SHIFT
RELEASE_SHIFT, 8, loop shift used when err >= 0
GAIN_INIT, 256, reset gain in gain LSBs (1.0)
GAIN_MIN, 16, lower gain clamp in LSBs (0.0625)
GAIN_MAX, 16384, upper gain clamp in LSBs (64.0)
LOCK_TOL, 256, lock tolerance on |err| in sample LSBs
LOCK_CNT, 16, consecutive in-tolerance updates needed to assert locked

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
in_valid  in  1  input sample qualifier
in_real  in  SAMPLE_W  input I
in_imag  in  SAMPLE_W  input Q
target  in  SAMPLE_W  target peak magnitude, unsigned, 0..2^(SAMPLE_W-1)-1
hold  in  1  freeze gain accumulator and lock counter
gain_load  in  1  one-cycle strobe, preload gain
gain_load_val  in  GAIN_W  preload value in gain LSBs
out_valid  out  1  output sample qualifier
out_real  out  SAMPLE_W  scaled I
out_imag  out  SAMPLE_W  scaled Q
gain  out  GAIN_W  current gain, Q(GAIN_W-GAIN_FR).GAIN_FR
sat  out  1  output saturated on this out_valid sample
locked  out  1  loop settled

Behaviour:
- Reset is nrst, asynchronous, active-low; clock is clk.
- Reset values:
  - out_valid, out_real, out_imag, sat, locked = 0.
  - Lock counter = 0.
  - acc = GAIN_INIT << K, so gain = GAIN_INIT.
- Accumulator acc:
  - Signed; ACC_FR = SAMPLE_FR + RELEASE_SHIFT fractional bits.
  - K = ACC_FR - GAIN_FR.
  - gain = (acc + 2^(K-1)) >>> K, combinational from acc.
- Stage 1, on an edge with in_valid=1:
  - p_r = in_real * gain and p_i = in_imag * gain, signed full-width products, registered.
  - Valid flag delayed one cycle.
- Stage 2:
  - r = (p + 2^(GAIN_FR-1)) >>> GAIN_FR.
  - Saturate r to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and register to out_*.
  - out_valid = delayed valid. Latency is exactly 2 cycles, accepting back-to-back samples every cycle.
  - sat = 1 with out_valid if either channel clipped, else 0.
  - out_* hold their value when out_valid=0.
- Gain update, on the edge after an out_valid=1 cycle:
  - mag = max(|out_real|, |out_imag|), unsigned; |-2^(SAMPLE_W-1)| saturates to 2^(SAMPLE_W-1)-1.
  - err = target - mag, signed, SAMPLE_W+1 bits.
  - shift = ATTACK_SHIFT if err < 0, else RELEASE_SHIFT.
  - acc_next = acc + (err << (RELEASE_SHIFT - shift)), sign-extended.
  - Clamp acc_next to [GAIN_MIN<<K, GAIN_MAX<<K].
  - The new gain applies to inputs accepted from the following edge onward.
- Lock counter, on each performed update:
  - If |err| <= LOCK_TOL, increment, saturating at LOCK_CNT; otherwise clear to 0.
  - locked = (count == LOCK_CNT), registered.
- Priority on each edge: gain_load > hold > update.
  - gain_load: acc <= clamp(gain_load_val) << K; lock counter and locked cleared; the pending update is discarded.
  - hold=1: acc, lock counter and locked retained. The datapath keeps running with the frozen gain.
- in_valid during gain_load or hold is processed normally.
- Reset mid-stream: in-flight samples are dropped; out_valid is 0 at the first edge after release.
- target changes take effect at the next update. No handshake back-pressure; the block is always ready.

Test Plan:
- Passthrough: reset, hold=1, gain=256; in=(0x1000,0xF000) for 1 cycle -> two edges later out=(0x1000,0xF000), out_valid=1 for exactly 1 cycle, sat=0.
- Saturation: gain_load 512, hold=1; in=(0x6000,0xA000) -> out=(0x7FFF,0x8000), sat=1; next in=(0x1000,0) -> out=(0x2000,0), sat=0.
- Release convergence: target=0x2000, in=(0x0400,0) every cycle, hold=0 -> gain rises monotonically to 2048±2; locked asserts after 16 consecutive |err|<=256 updates; gain never exceeds 16384.
- Attack step: after lock, step to in=(0x4000,0) -> first out saturates; first update err=-24575, gain drops by 24 LSB; locked falls the cycle after that update; gain settles near 128.
- Clamps: target=0x7FFF, in=0, gain_load 16380 -> gain reaches 16384 and stays. Target=0, in=(0x4000,0), gain_load 20 -> gain clamps at 16 and stays.
- Priority/reset: gain_load 300 on the same edge as an update -> gain=300, locked=0. hold=1 -> gain constant for 100 samples. nrst pulse mid-stream -> out_valid=0, gain=256 immediately.

Source files
------------

// File: rtl/agc_dual_rate.sv
// agc_dual_rate: closed-loop I/Q automatic gain control, fast attack (gain down) / slow release (gain up).
// Latency: 2 cycles from in_valid to out_valid, one sample per cycle sustained.
// Backpressure: none; always ready, out_valid is in_valid delayed by two cycles.
// Ports: clk, nrst; in_valid/in_real/in_imag sample in; target, hold, gain_load/gain_load_val loop control;
//        out_valid/out_real/out_imag/sat scaled sample out; gain, locked loop status.
module agc_dual_rate #(
  parameter int SAMPLE_W      = 16,
  parameter int SAMPLE_FR     = 15,
  parameter int GAIN_W        = 16,
  parameter int GAIN_FR       = 8,
  parameter int ATTACK_SHIFT  = 3,
  parameter int RELEASE_SHIFT = 8,
  parameter int GAIN_INIT     = 256,
  parameter int GAIN_MIN      = 16,
  parameter int GAIN_MAX      = 16384,
  parameter int LOCK_TOL      = 256,
  parameter int LOCK_CNT      = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_real,
  input  logic [SAMPLE_W-1:0] in_imag,
  input  logic [SAMPLE_W-1:0] target,
  input  logic                hold,
  input  logic                gain_load,
  input  logic [GAIN_W-1:0]   gain_load_val,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_real,
  output logic [SAMPLE_W-1:0] out_imag,
  output logic [GAIN_W-1:0]   gain,
  output logic                sat,
  output logic                locked
);

  localparam int ACC_FR  = SAMPLE_FR + RELEASE_SHIFT;
  localparam int K       = ACC_FR - GAIN_FR;
  localparam int ACC_W   = GAIN_W + K + 2;
  localparam int PROD_W  = SAMPLE_W + GAIN_W;
  localparam int RW      = PROD_W + 1;
  localparam int ERR_W   = SAMPLE_W + 1;
  localparam int CNT_W   = $clog2(LOCK_CNT + 1);
  localparam int STEP_SH = RELEASE_SHIFT - ATTACK_SHIFT;

  localparam logic signed [ACC_W-1:0] ACC_MIN  = ACC_W'(longint'(GAIN_MIN) <<< K);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(longint'(GAIN_MAX) <<< K);
  localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(longint'(GAIN_INIT) <<< K);
  localparam logic signed [ACC_W-1:0] ACC_HALF = ACC_W'(longint'(1) <<< (K - 1));
  localparam logic signed [RW-1:0]    RND      = RW'(longint'(1) <<< (GAIN_FR - 1));
  localparam logic signed [RW-1:0]    SMAX     = RW'((longint'(1) <<< (SAMPLE_W - 1)) - 1);
  localparam logic signed [RW-1:0]    SMIN     = RW'(-(longint'(1) <<< (SAMPLE_W - 1)));
  localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(LOCK_CNT);

  function automatic logic [SAMPLE_W-1:0] clip(input logic signed [RW-1:0] v);
    if (v > SMAX)      return SMAX[SAMPLE_W-1:0];
    else if (v < SMIN) return SMIN[SAMPLE_W-1:0];
    else               return v[SAMPLE_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [RW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  // |x| with the most negative code folded onto the most positive one
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] x);
    if (!x[SAMPLE_W-1])                             return x;
    else if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})     return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else                                            return -x;
  endfunction

  // Loop state
  logic signed [ACC_W-1:0] acc, acc_rnd, acc_sum, acc_upd;
  logic signed [ACC_W-1:0] err_x, delta, ld_x, ld_sh, ld_acc;
  logic [CNT_W-1:0]        cnt, cnt_nxt;

  // Datapath
  logic signed [PROD_W-1:0] in_r_x, in_i_x, gain_x, mul_r, mul_i, p_r, p_i;
  logic signed [RW-1:0]     r_r, r_i;
  logic                     vld_d;

  // Error path
  logic [SAMPLE_W-1:0]     mag_r, mag_i, mag;
  logic signed [ERR_W-1:0] err;
  logic [ERR_W-1:0]        err_abs;
  logic                    in_tol;
  logic                    unused_ok;

  // Rounded gain is the accumulator's integer view at gain resolution
  assign acc_rnd   = acc + ACC_HALF;
  assign gain      = acc_rnd[K +: GAIN_W];
  assign unused_ok = ^{acc_rnd[K-1:0], acc_rnd[ACC_W-1:K+GAIN_W]};

  assign in_r_x = {{GAIN_W{in_real[SAMPLE_W-1]}}, in_real};
  assign in_i_x = {{GAIN_W{in_imag[SAMPLE_W-1]}}, in_imag};
  assign gain_x = {{SAMPLE_W{1'b0}}, gain};
  assign mul_r  = in_r_x * gain_x;
  assign mul_i  = in_i_x * gain_x;

  // Round half up, then drop gain fraction bits
  assign r_r = ($signed({p_r[PROD_W-1], p_r}) + RND) >>> GAIN_FR;
  assign r_i = ($signed({p_i[PROD_W-1], p_i}) + RND) >>> GAIN_FR;

  assign mag_r   = abs_sat(out_real);
  assign mag_i   = abs_sat(out_imag);
  assign mag     = (mag_r >= mag_i) ? mag_r : mag_i;
  assign err     = $signed({1'b0, target}) - $signed({1'b0, mag});
  assign err_abs = err[ERR_W-1] ? -err : err;
  assign in_tol  = (err_abs <= ERR_W'(LOCK_TOL));

  // Accumulator carries RELEASE_SHIFT extra fraction bits, so the release step adds err
  // directly and the attack step is err pre-scaled by the shift difference.
  assign err_x   = {{(ACC_W-ERR_W){err[ERR_W-1]}}, err};
  assign delta   = err[ERR_W-1] ? (err_x <<< STEP_SH) : err_x;
  assign acc_sum = acc + delta;

  assign ld_x  = {{(ACC_W-GAIN_W){gain_load_val[GAIN_W-1]}}, gain_load_val};
  assign ld_sh = ld_x <<< K;

  always_comb begin
    acc_upd = acc_sum;
    if (acc_sum < ACC_MIN)      acc_upd = ACC_MIN;
    else if (acc_sum > ACC_MAX) acc_upd = ACC_MAX;
    ld_acc = ld_sh;
    if (ld_sh < ACC_MIN)        ld_acc = ACC_MIN;
    else if (ld_sh > ACC_MAX)   ld_acc = ACC_MAX;
    cnt_nxt = '0;
    if (in_tol) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_d     <= 1'b0;
      p_r       <= '0;
      p_i       <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      sat       <= 1'b0;
      acc       <= ACC_INIT;
      cnt       <= '0;
      locked    <= 1'b0;
    end else begin
      vld_d <= in_valid;
      if (in_valid) begin
        p_r <= mul_r;
        p_i <= mul_i;
      end

      out_valid <= vld_d;
      if (vld_d) begin
        out_real <= clip(r_r);
        out_imag <= clip(r_i);
        sat      <= clipped(r_r) || clipped(r_i);
      end else begin
        sat <= 1'b0;
      end

      // Preload beats hold, hold beats the loop update
      if (gain_load) begin
        acc    <= ld_acc;
        cnt    <= '0;
        locked <= 1'b0;
      end else if (!hold) begin
        locked <= (cnt == CNT_MAX);
        if (out_valid) begin
          acc <= acc_upd;
          cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_agc_dual_rate.sv
module tb_agc_dual_rate;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid, hold, gain_load;
  logic [15:0] in_real, in_imag, target, gain_load_val;
  logic        out_valid, sat, locked;
  logic [15:0] out_real, out_imag, gain;

  always #5 clk = ~clk;

  agc_dual_rate dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .target(target), .hold(hold), .gain_load(gain_load), .gain_load_val(gain_load_val),
    .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag), .gain(gain),
    .sat(sat), .locked(locked)
  );

  typedef struct { logic [15:0] r; logic [15:0] i; logic s; } exp_t;
  typedef struct {
    logic [15:0] lv; logic [15:0] r; logic [15:0] i;
    logic [15:0] eg; logic [15:0] er; logic [15:0] ei; logic es;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  longint m_acc;
  int     m_cnt;
  bit     m_locked, m_v1, m_ov;
  exp_t   m_s1, m_out;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint m_gain();
    return (m_acc + 64'sd16384) >>> 15;
  endfunction

  function automatic longint m_mag(input logic [15:0] x);
    longint v;
    v = longint'($signed(x));
    if (v < 0) v = (v == -32768) ? 32767 : -v;
    return v;
  endfunction

  function automatic exp_t m_scale(input longint r, input longint i, input longint g);
    exp_t   e;
    longint a, b;
    e.s = 1'b0;
    a = (r * g + 128) >>> 8;
    b = (i * g + 128) >>> 8;
    if (a > 32767)  begin a = 32767;  e.s = 1'b1; end
    if (a < -32768) begin a = -32768; e.s = 1'b1; end
    if (b > 32767)  begin b = 32767;  e.s = 1'b1; end
    if (b < -32768) begin b = -32768; e.s = 1'b1; end
    e.r = a[15:0];
    e.i = b[15:0];
    return e;
  endfunction

  function automatic longint clamp_acc(input longint a);
    if (a < 64'sd16 * 32768)    return 64'sd16 * 32768;
    if (a > 64'sd16384 * 32768) return 64'sd16384 * 32768;
    return a;
  endfunction

  task automatic model_reset();
    m_acc    = 64'sd256 * 32768;
    m_cnt    = 0;
    m_locked = 1'b0;
    m_v1     = 1'b0;
    m_ov     = 1'b0;
    m_out    = '{r: 16'h0, i: 16'h0, s: 1'b0};
    m_s1     = '{r: 16'h0, i: 16'h0, s: 1'b0};
    sb.delete();
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    longint g, err, ae;
    exp_t   e;
    g = m_gain();
    if (gain_load) begin
      m_acc    = clamp_acc(longint'($signed(gain_load_val)) * 32768);
      m_cnt    = 0;
      m_locked = 1'b0;
    end else if (!hold) begin
      m_locked = (m_cnt == 16);
      if (m_ov) begin
        err   = longint'(target) - ((m_mag(m_out.r) >= m_mag(m_out.i)) ? m_mag(m_out.r) : m_mag(m_out.i));
        m_acc = clamp_acc(m_acc + ((err < 0) ? err * 32 : err));
        ae    = (err < 0) ? -err : err;
        m_cnt = (ae <= 256) ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
      end
    end
    if (m_v1) m_out = m_s1;
    m_ov = m_v1;
    if (in_valid) begin
      e = m_scale(longint'($signed(in_real)), longint'($signed(in_imag)), g);
      m_s1 = e;
      sb.push_back(e);
    end
    m_v1 = in_valid;
  endtask

  task automatic check_cycle();
    exp_t e;
    chk("out_valid", out_valid, m_ov);
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: out_valid with no expected sample at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("out_real", out_real, e.r);
        chk("out_imag", out_imag, e.i);
        chk("sat", sat, e.s);
      end
    end else begin
      chk("sat_idle", sat, 0);
    end
    chk("gain", gain, m_gain());
    chk("locked", locked, m_locked);
  endtask

  task automatic cyc(input bit v, input logic [15:0] r, input logic [15:0] i,
                     input bit h, input bit ld, input logic [15:0] lv);
    in_valid = v; in_real = r; in_imag = i;
    hold = h; gain_load = ld; gain_load_val = lv;
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  initial begin
    int     viol;
    int     gmax;
    longint prev, g0;

    tbl[0] = '{16'd256,   16'h1000, 16'hF000, 16'd256,   16'h1000, 16'hF000, 1'b0};
    tbl[1] = '{16'd512,   16'h6000, 16'hA000, 16'd512,   16'h7FFF, 16'h8000, 1'b1};
    tbl[2] = '{16'd512,   16'h1000, 16'h0000, 16'd512,   16'h2000, 16'h0000, 1'b0};
    tbl[3] = '{16'd384,   16'h0003, 16'hFFFD, 16'd384,   16'h0005, 16'hFFFC, 1'b0};
    tbl[4] = '{16'd16,    16'h7FFF, 16'h8000, 16'd16,    16'h0800, 16'hF800, 1'b0};
    tbl[5] = '{16'd16384, 16'h0200, 16'hFE00, 16'd16384, 16'h7FFF, 16'h8000, 1'b1};
    tbl[6] = '{16'd128,   16'h01FF, 16'hFFFF, 16'd128,   16'h0100, 16'h0000, 1'b0};
    tbl[7] = '{16'd20000, 16'h0001, 16'h0000, 16'd16384, 16'h0040, 16'h0000, 1'b0};
    tbl[8] = '{16'hFF00,  16'h0100, 16'h0000, 16'd16,    16'h0010, 16'h0000, 1'b0};

    nrst = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    target = '0; hold = 1'b1; gain_load = 1'b0; gain_load_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_imag", out_imag, 0);
    chk("rst_sat", sat, 0);
    chk("rst_locked", locked, 0);
    chk("rst_gain", gain, 256);
    nrst = 1'b1;

    // Table: preload gain under hold, push one sample, expect it exactly two edges later
    for (int k = 0; k < 9; k++) begin
      cyc(0, 16'h0, 16'h0, 1, 1, tbl[k].lv);
      chk($sformatf("vec%0d_gain", k), gain, tbl[k].eg);
      cyc(1, tbl[k].r, tbl[k].i, 1, 0, 16'h0);
      chk($sformatf("vec%0d_lat1", k), out_valid, 0);
      cyc(0, 16'h0, 16'h0, 1, 0, 16'h0);
      chk($sformatf("vec%0d_vld", k), out_valid, 1);
      chk($sformatf("vec%0d_real", k), out_real, tbl[k].er);
      chk($sformatf("vec%0d_imag", k), out_imag, tbl[k].ei);
      chk($sformatf("vec%0d_sat", k), sat, tbl[k].es);
      cyc(0, 16'h0, 16'h0, 1, 0, 16'h0);
      chk($sformatf("vec%0d_once", k), out_valid, 0);
      chk($sformatf("vec%0d_hold_out", k), out_real, tbl[k].er);
    end

    // Release convergence toward gain 2048 (out = 4*gain, target 0x2000)
    target = 16'h2000;
    cyc(0, 16'h0, 16'h0, 0, 1, 16'd2020);
    viol = 0; gmax = 0; prev = 2020;
    for (int n = 0; n < 26000; n++) begin
      cyc(1, 16'h0400, 16'h0, 0, 0, 16'h0);
      if (longint'(gain) < prev) viol++;
      if (int'(gain) > gmax) gmax = int'(gain);
      prev = longint'(gain);
    end
    chk("release_monotonic_violations", viol, 0);
    chk("release_never_above_max", (gmax <= 16384), 1);
    chk("release_gain_near_2048", (gain >= 16'd2046 && gain <= 16'd2050), 1);
    chk("release_locked", locked, 1);

    // Attack step: output clips, first update drops gain by ~24 LSB
    g0 = m_gain();
    cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    chk("attack_first_out", out_real, 16'h7FFF);
    chk("attack_first_sat", sat, 1);
    cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    chk("attack_drop_about_24", ((g0 - longint'(gain)) >= 23 && (g0 - longint'(gain)) <= 25), 1);
    chk("attack_locked_still", locked, 1);
    cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    chk("attack_locked_falls", locked, 0);
    repeat (600) cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    chk("attack_settle_128", (gain >= 16'd126 && gain <= 16'd130), 1);

    // Preload on the same edge as a pending update wins; then hold freezes the loop
    cyc(1, 16'h4000, 16'h0, 0, 1, 16'd300);
    chk("prio_gain_300", gain, 300);
    chk("prio_locked_clear", locked, 0);
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      cyc(1, 16'h4000, 16'h0, 1, 0, 16'h0);
      if (gain != 16'd300) viol++;
    end
    chk("hold_gain_changes", viol, 0);

    // Upper clamp
    target = 16'h7FFF;
    cyc(0, 16'h0, 16'h0, 0, 1, 16'd16380);
    repeat (20) cyc(1, 16'h0, 16'h0, 0, 0, 16'h0);
    chk("clamp_max_reach", gain, 16384);
    repeat (20) cyc(1, 16'h0, 16'h0, 0, 0, 16'h0);
    chk("clamp_max_stay", gain, 16384);

    // Lower clamp
    target = 16'h0000;
    cyc(0, 16'h0, 16'h0, 0, 1, 16'd20);
    repeat (20) cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    chk("clamp_min_reach", gain, 16);
    repeat (20) cyc(1, 16'h4000, 16'h0, 0, 0, 16'h0);
    chk("clamp_min_stay", gain, 16);

    // Asynchronous reset mid-stream
    target = 16'h1000;
    repeat (5) cyc(1, 16'h1000, 16'h1000, 0, 0, 16'h0);
    #1 nrst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_gain", gain, 256);
    chk("arst_locked", locked, 0);
    chk("arst_sat", sat, 0);
    model_reset();
    #1 nrst = 1'b1;
    cyc(1, 16'h1000, 16'h1000, 0, 0, 16'h0);
    chk("arst_first_edge_vld", out_valid, 0);
    repeat (5) cyc(1, 16'h1000, 16'h1000, 0, 0, 16'h0);
    repeat (3) cyc(0, 16'h0, 16'h0, 0, 0, 16'h0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
